unsigned_approx_mult_pipe: RTL

UNSIGNED_APPROX_MULT_PIPE -- requirements
Module: unsigned_approx_mult_pipe

---
 rtl/unsigned_approx_mult_pkg.sv | 33 +++
 rtl/unsigned_approx_mult_pipe_if.sv | 30 +++
 rtl/unsigned_approx_mult_pipe_approx_pp_reduce.sv | 32 +++
 rtl/unsigned_approx_mult_pipe.sv | 121 ++++++++++++
 4 files changed

// File: rtl/unsigned_approx_mult_pkg.sv
// Shared definitions for the approximate unsigned multiplier pipeline.
// Holds the pipeline depth, the parameter legality check and a reference
// function for the truncated low partial-product term S.
package unsigned_approx_mult_pkg;

    localparam int unsigned NumStages = 3;

    // True when operand width, approximated-row count and truncation column
    // form a legal combination.
    function automatic bit params_legal(int unsigned n, int unsigned l, int unsigned t);
        return (n >= 4) && (n <= 32) && (l >= 1) && (l + 1 <= n) && (t + 2 <= n + l);
    endfunction

    // Truncated low term S: rows 0..l-1 of the partial-product array with every
    // bit below column t cleared before they are summed. Only n bits of y count.
    function automatic logic [63:0] trunc_low_term(int unsigned n, int unsigned l,
                                                   int unsigned t, logic [31:0] x_lo,
                                                   logic [31:0] y);
        logic [63:0] acc;
        logic [63:0] keep;
        logic [63:0] y_n;
        acc  = '0;
        keep = {64{1'b1}} << t;
        y_n  = {32'b0, y} & ~({64{1'b1}} << n);
        for (int unsigned i = 0; i < 32; i++) begin
            if ((i < l) && x_lo[i]) begin
                acc = acc + ((y_n << i) & keep);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/unsigned_approx_mult_pipe_if.sv
// Handshake bundle for unsigned_approx_mult_pipe.
//   in_valid/in_ready : operand beat (x, y, mode) transfer
//   out_valid/out_ready : result beat (z, err, z_approx) transfer
// master drives operands and out_ready; slave is the multiplier.
interface unsigned_approx_mult_pipe_if #(
    parameter int unsigned N = 8
) ();

    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] z;
    logic [2*N-1:0] err;
    logic           z_approx;

    modport master (
        output in_valid, x, y, mode, out_ready,
        input  in_ready, out_valid, z, err, z_approx
    );

    modport slave (
        input  in_valid, x, y, mode, out_ready,
        output in_ready, out_valid, z, err, z_approx
    );

endinterface

// File: rtl/unsigned_approx_mult_pipe_approx_pp_reduce.sv
// approx_pp_reduce: combinational sum of the low L partial-product rows
// (x_lo_i[i] ? y_i << i : 0), each truncated below column T.
//   x_lo_i : low L bits of the multiplier
//   y_i    : multiplicand
//   s_o    : truncated low term S (fits in N+L bits)
module approx_pp_reduce #(
    parameter int unsigned N = 8,
    parameter int unsigned L = 4,
    parameter int unsigned T = N - 1
) (
    input  logic [L-1:0]   x_lo_i,
    input  logic [N-1:0]   y_i,
    output logic [N+L-1:0] s_o
);

    localparam int unsigned W = N + L;
    localparam logic [W-1:0] KeepMask = {W{1'b1}} << T;

    logic [W-1:0] y_ext;

    assign y_ext = {{L{1'b0}}, y_i};

    always_comb begin
        s_o = '0;
        for (int i = 0; i < int'(L); i++) begin
            if (x_lo_i[i]) begin
                s_o = s_o + ((y_ext << i) & KeepMask);
            end
        end
    end

endmodule

// File: rtl/unsigned_approx_mult_pipe.sv
// unsigned_approx_mult_pipe: 3-stage valid/ready pipelined unsigned multiplier
// with a per-beat exact/approximate select.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of unsigned_approx_mult_pipe_if (operands in,
//              product z, error err = exact - z, z_approx = ~mode out)
// S1 captures operands, S2 forms the high product, truncated low term and the
// exact product, S3 forms z and err. Each stage loads when it is empty or
// when the stage after it can take its contents, so bubbles collapse.
module unsigned_approx_mult_pipe
    import unsigned_approx_mult_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned L = 4,
    parameter int unsigned T = N - 1
) (
    input logic                        clk,
    input logic                        rst,
    unsigned_approx_mult_pipe_if.slave bus
);

    if (!params_legal(N, L, T)) begin : g_illegal
        $error("unsigned_approx_mult_pipe: illegal N/L/T combination");
    end

    localparam int unsigned PW  = 2 * N;
    localparam int unsigned HiW = 2 * N - L;

    // Stage valid flags and per-stage ready (stage can load this cycle).
    logic v1_q, v2_q, v3_q;
    logic rdy1, rdy2, rdy3;

    // S1: captured operands.
    logic [N-1:0] x1_q, y1_q;
    logic         m1_q;

    // S2: high product, truncated low term, exact product.
    logic [HiW-1:0] hi2_q, hi2_d;
    logic [N+L-1:0] s2_q, s2_d;
    logic [PW-1:0]  p2_q, p2_d;
    logic           m2_q;

    // S3: registered outputs.
    logic [PW-1:0] z3_q, z3_d;
    logic [PW-1:0] err3_q, err3_d;
    logic          za3_q;
    logic [PW-1:0] z_apx;

    assign rdy3 = ~v3_q | bus.out_ready;
    assign rdy2 = ~v2_q | rdy3;
    assign rdy1 = ~v1_q | rdy2;

    approx_pp_reduce #(
        .N(N),
        .L(L),
        .T(T)
    ) u_reduce (
        .x_lo_i(x1_q[L-1:0]),
        .y_i   (y1_q),
        .s_o   (s2_d)
    );

    assign hi2_d = HiW'(y1_q) * HiW'(x1_q[N-1:L]);
    assign p2_d  = PW'(x1_q) * PW'(y1_q);

    // Approximate result never exceeds the exact one, so err cannot wrap.
    assign z_apx  = {hi2_q, {L{1'b0}}} + {{(N - L){1'b0}}, s2_q};
    assign z3_d   = m2_q ? p2_q : z_apx;
    assign err3_d = p2_q - z3_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            x1_q   <= '0;
            y1_q   <= '0;
            m1_q   <= 1'b0;
            hi2_q  <= '0;
            s2_q   <= '0;
            p2_q   <= '0;
            m2_q   <= 1'b0;
            z3_q   <= '0;
            err3_q <= '0;
            za3_q  <= 1'b0;
        end else begin
            if (rdy1) begin
                v1_q <= bus.in_valid;
                if (bus.in_valid) begin
                    x1_q <= bus.x;
                    y1_q <= bus.y;
                    m1_q <= bus.mode;
                end
            end
            if (rdy2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    hi2_q <= hi2_d;
                    s2_q  <= s2_d;
                    p2_q  <= p2_d;
                    m2_q  <= m1_q;
                end
            end
            // Data only moves when S3 can hand off, so outputs hold in a stall.
            if (rdy3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    z3_q   <= z3_d;
                    err3_q <= err3_d;
                    za3_q  <= ~m2_q;
                end
            end
        end
    end

    assign bus.in_ready  = rdy1;
    assign bus.out_valid = v3_q;
    assign bus.z         = z3_q;
    assign bus.err       = err3_q;
    assign bus.z_approx  = za3_q;

endmodule
